lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller that acts on the memory control word produced by the instruction decoder: `mem_read`, `mem_write` and the byte-lane mask `mem_mask`. It sits in the execute/memory stage between the ALU address result and the data-memory bus. It converts a byte/half/word request into one word-aligned bus transaction with shifted byte enables and data. It stalls the pipeline until the transaction completes or times out.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent waiting for `bus_ready` before the access is aborted (1..255).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_read` in 1: load request (decoder `mem_read`).
- `req_write` in 1: store request (decoder `mem_write`).
- `req_mask` in 4: lane mask (decoder `mem_mask`): 0001 byte, 0011 half, 1111 word.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data, right-aligned (rt value).
- `stall` out 1: hold the pipeline; combinational.
- `rdata` out 32: load result, zero-extended, right-aligned.
- `rdata_valid` out 1: one-cycle pulse; `rdata` is valid in this cycle.
- `err_misaligned` out 1: one-cycle pulse; the request crosses the word boundary or has an illegal mask.
- `err_timeout` out 1: one-cycle pulse; the bus did not respond within `TIMEOUT` cycles.
- `bus_valid` out 1: transaction request.
- `bus_ready` in 1: bus accepts/completes the transaction.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, bits [1:0] = 00.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-shifted write data.
- `bus_rdata` in 32: read word; sampled on the handshake.

## Operation
- `go` = `req_read | req_write`.
  - When both are asserted, the request is a write and `req_read` is ignored.
- `off` = `req_addr[1:0]`.
- `be` = `req_mask << off`, computed in 4 bits.
- Misaligned condition: any mask bit is shifted out, or `req_mask` is not one of {0001, 0011, 1111}.
- `bus_wdata` = `req_wdata << (8*off)`.
- Load result: `rdata` = `(bus_rdata >> 8*off)` ANDed with the expansion of `req_mask` (0x000000FF, 0x0000FFFF or 0xFFFFFFFF).
- States: IDLE, BUSY, DONE.
  - IDLE, `go` and aligned: latch address, be, wdata, we, off and mask; clear the timeout counter; go to BUSY.
  - IDLE, `go` and misaligned: no bus access; `err_misaligned` pulses next cycle; go to DONE.
  - BUSY: `bus_valid` = 1, with all bus outputs held stable.
    - `bus_valid & bus_ready`: capture the (masked) read data; go to DONE.
    - Otherwise the counter increments. When it reaches `TIMEOUT`, `err_timeout` pulses and the FSM goes to DONE with `rdata` = 0.
  - DONE: `rdata_valid` = 1 for loads, 0 for stores; `stall` = 0; the pipeline advances on this edge. The next state is always IDLE.
    - The request present during DONE is the completed instruction and is ignored.
- `stall` = `(IDLE & go & !rst) | BUSY`.

## Timing
- Reset values:
  - State IDLE.
  - `bus_valid`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`: 0.
  - `rdata`: 0.
  - `rdata_valid`, `err_misaligned`, `err_timeout`: 0.
  - `stall`: 0 while `rst` is high.
- Minimum latency with `bus_ready` already high: request seen in cycle 0 (`stall` = 1), `bus_valid` in cycle 1, DONE in cycle 2. Total: 3 cycles, 2 of them stalled.
- Each wait cycle with `bus_ready` low adds one cycle.
- Bus handshake:
  - `bus_valid` never drops before `bus_ready` is seen.
  - Bus outputs do not change while `bus_valid` = 1.
  - `bus_ready` is ignored outside BUSY.
- Timeout: if `bus_ready` is never asserted, DONE is entered exactly `TIMEOUT` + 1 cycles after BUSY is entered.
- Misaligned access: stall for 1 cycle (IDLE), then DONE. `bus_valid` stays 0 throughout.
- Reset while BUSY: the FSM is in IDLE next cycle and `bus_valid` = 0. No `rdata_valid` and no error pulse are produced.
- Back-to-back accesses: the earliest next issue is the cycle after DONE.

## Structure
- Shared define header (`include/define.v`) gains:
  - Mask constants `MEM_MASK_BYTE`/`HALF`/`WORD`.
  - LSU state encodings `LSU_IDLE`/`BUSY`/`DONE`.
- `lsu_ctrl` holds the FSM and timeout counter (8-bit).
- Sub-module `lsu_lane_align` (combinational): takes `off` and `mask`, and produces `be`, misaligned, shifted write data and extracted read data.

## Test plan
- Word store: `addr` 0x100, mask 1111, `wdata` 0xDEADBEEF, `bus_ready` high → `bus_addr` 0x100, `be` 1111, `bus_wdata` 0xDEADBEEF, `we` = 1; `stall` high 2 cycles; `rdata_valid` stays 0.
- Byte store: `addr` 0x103, mask 0001, `wdata` 0x000000AB → `bus_addr` 0x100, `be` 1000, `bus_wdata` 0xAB000000.
- Half load with 3-cycle `bus_ready` delay: `addr` 0x202, mask 0011, `bus_rdata` 0x12345678 → `rdata` 0x00001234 and `rdata_valid` pulse in cycle 5; `stall` high in cycles 0–4.
- Misaligned: half at 0x203, and word at 0x101 → `err_misaligned` pulse, `bus_valid` never asserted, `stall` high exactly 1 cycle.
- `TIMEOUT` = 4, `bus_ready` held low → `err_timeout` pulse, `rdata` 0, `bus_valid` high exactly 5 cycles.
- Reset asserted in the 2nd BUSY cycle → next cycle `bus_valid` 0, `stall` 0, state IDLE; no pulses.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU types: lane-mask codes, FSM states, mask legality helper.
// Imported by the LSU interface, lane aligner and controller.
package lsu_ctrl_pkg;

  localparam logic [3:0] MEM_MASK_BYTE = 4'b0001;
  localparam logic [3:0] MEM_MASK_HALF = 4'b0011;
  localparam logic [3:0] MEM_MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  function automatic logic mask_legal(
    input logic [3:0] m
  );
    return (m == MEM_MASK_BYTE) ||
           (m == MEM_MASK_HALF) ||
           (m == MEM_MASK_WORD);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus: valid/ready request with word address, byte enables,
// write data and read data. master = LSU, slave = memory.
interface lsu_ctrl_if;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: off/mask -> byte enables, misalignment,
// shifted store data and zero-extended right-aligned load data.
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  mask,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  be_wide;
  logic [31:0] keep;

  always_comb begin
    be_wide    = {4'b0000, mask} << off;
    be         = be_wide[3:0];
    // any lane pushed past byte 3 crosses the word boundary
    misaligned = (|be_wide[7:4]) || !mask_legal(mask);
    wdata_sh   = wdata << {off, 3'b000};
    keep       = {{8{mask[3]}}, {8{mask[2]}},
                  {8{mask[1]}}, {8{mask[0]}}};
    rdata_ext  = (rword >> {off, 3'b000}) & keep;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one aligned bus transaction per request, stalls
// the pipeline until done or timed out. Ports: req_*, stall, rdata*, err_*, bus.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err_misaligned,
  output logic        err_timeout,
  lsu_ctrl_if.master  bus
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [3:0]  mask_q;
  logic        go;
  logic        idle;
  logic [1:0]  off_sel;
  logic [3:0]  mask_sel;
  logic [3:0]  be;
  logic        mis;
  logic [31:0] wsh;
  logic [31:0] rext;

  assign go   = req_read | req_write;
  assign idle = (state == LSU_IDLE);

  // request fields while issuing, latched fields while on the bus
  assign off_sel  = idle ? req_addr[1:0] : off_q;
  assign mask_sel = idle ? req_mask      : mask_q;

  lsu_lane_align u_align (
    .off        (off_sel),
    .mask       (mask_sel),
    .wdata      (req_wdata),
    .rword      (bus.bus_rdata),
    .be         (be),
    .misaligned (mis),
    .wdata_sh   (wsh),
    .rdata_ext  (rext)
  );

  assign stall = (idle && go && !rst) || (state == LSU_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LSU_IDLE;
      cnt            <= 8'd0;
      off_q          <= 2'd0;
      mask_q         <= 4'd0;
      rdata          <= 32'd0;
      rdata_valid    <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      bus.bus_valid  <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= 32'd0;
      bus.bus_be     <= 4'd0;
      bus.bus_wdata  <= 32'd0;
    end else begin
      rdata_valid    <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      unique case (state)
        LSU_IDLE: begin
          if (go && mis) begin
            err_misaligned <= 1'b1;
            rdata_valid    <= !req_write;
            rdata          <= 32'd0;
            state          <= LSU_DONE;
          end else if (go) begin
            bus.bus_valid <= 1'b1;
            bus.bus_we    <= req_write;
            bus.bus_addr  <= {req_addr[31:2], 2'b00};
            bus.bus_be    <= be;
            bus.bus_wdata <= wsh;
            off_q         <= req_addr[1:0];
            mask_q        <= req_mask;
            cnt           <= 8'd0;
            state         <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (bus.bus_ready) begin
            bus.bus_valid <= 1'b0;
            rdata_valid   <= !bus.bus_we;
            if (!bus.bus_we) rdata <= rext;
            state <= LSU_DONE;
          end else if (cnt == TO_LIM) begin
            bus.bus_valid <= 1'b0;
            err_timeout   <= 1'b1;
            rdata_valid   <= !bus.bus_we;
            rdata         <= 32'd0;
            state         <= LSU_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random
// accesses against a byte-arithmetic reference model.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [3:0]  req_mask;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, err_misaligned, err_timeout;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if bus_if ();

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_mask       (req_mask),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .bus            (bus_if.master)
  );

  typedef struct {
    int          stall_c;
    int          valid_c;
    int          rv_c;
    int          mis_c;
    int          to_c;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    bit          unstable;
    bit          hung;
  } obs_t;

  // reference: lanes from access size and byte offset
  function automatic void model(
    input  logic [3:0]  mask,
    input  logic [31:0] addr, wd, brd,
    output bit          mis,
    output logic [3:0]  be,
    output logic [31:0] wsh,
    output logic [31:0] rext
  );
    int sz, off;
    off  = int'(addr % 4);
    sz   = (mask == 4'h1) ? 1 : (mask == 4'h3) ? 2 :
           (mask == 4'hF) ? 4 : 0;
    mis  = (sz == 0) || (off + sz > 4);
    be   = mis ? 4'h0 : 4'(((1 << sz) - 1) << off);
    wsh  = 32'(64'(wd) << (8 * off));
    rext = 32'((64'(brd) >> (8 * off)) &
               ((64'd1 << (8 * sz)) - 64'd1));
  endfunction

  // delay < 0 : bus never responds; else ready after delay waits
  function automatic bit times_out(input int delay);
    return (delay < 0) || (delay > TO);
  endfunction

  function automatic int exp_valid(input bit mis, input int delay);
    if (mis) return 0;
    return times_out(delay) ? TO + 1 : delay + 1;
  endfunction

  // drive one request, act as memory slave, record what the DUT did
  task automatic run_access(
    input  logic        rd, wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr, wd, brd,
    input  int          delay,
    output obs_t        o
  );
    int vc;
    bit done;
    o = '{default: 0};
    req_read  = rd;
    req_write = wr;
    req_mask  = mask;
    req_addr  = addr;
    req_wdata = wd;
    bus_if.bus_rdata = brd;
    bus_if.bus_ready = 1'b0;
    vc   = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (stall) o.stall_c++;
      if (bus_if.bus_valid) begin
        if (vc == 0) begin
          o.addr  = bus_if.bus_addr;
          o.be    = bus_if.bus_be;
          o.we    = bus_if.bus_we;
          o.wdata = bus_if.bus_wdata;
        end else if (o.addr !== bus_if.bus_addr ||
                     o.be !== bus_if.bus_be ||
                     o.we !== bus_if.bus_we ||
                     o.wdata !== bus_if.bus_wdata) begin
          o.unstable = 1;
        end
        vc++;
        bus_if.bus_ready = (delay >= 0) && (vc > delay);
      end else begin
        bus_if.bus_ready = 1'b0;
      end
      if (rdata_valid) begin
        o.rv_c++;
        o.rdata = rdata;
      end
      if (err_misaligned) o.mis_c++;
      if (err_timeout) o.to_c++;
      if (!stall) done = 1;
      @(posedge clk);
      #1;
    end
    o.valid_c = vc;
    o.hung    = !done;
    req_read  = 1'b0;
    req_write = 1'b0;
    bus_if.bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_read = 1'b1;
    req_mask = 4'hF;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got %b exp 0", stall);
    end
    n_checks++;
    if ({bus_if.bus_valid, bus_if.bus_we, bus_if.bus_be,
         bus_if.bus_addr, bus_if.bus_wdata} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_bus got v%b we%b be%h a%h d%h exp all 0",
               bus_if.bus_valid, bus_if.bus_we, bus_if.bus_be,
               bus_if.bus_addr, bus_if.bus_wdata);
    end
    n_checks++;
    if ({rdata, rdata_valid, err_misaligned, err_timeout} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_out got rd%h rv%b em%b et%b exp all 0",
               rdata, rdata_valid, err_misaligned, err_timeout);
    end
    req_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_word_store();
    obs_t o;
    run_access(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 0, o);
    n_checks++;
    if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b1) begin
      n_fail++;
      $display("FAIL word_store_bus got a%h be%h we%b exp a100 beF we1",
               o.addr, o.be, o.we);
    end
    n_checks++;
    if (o.wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_store_wdata got %h exp deadbeef", o.wdata);
    end
    n_checks++;
    if (o.stall_c !== 2 || o.hung) begin
      n_fail++;
      $display("FAIL word_store_stall got %0d exp 2", o.stall_c);
    end
    n_checks++;
    if (o.rv_c !== 0) begin
      n_fail++;
      $display("FAIL word_store_rvalid got %0d exp 0", o.rv_c);
    end
  endtask

  task automatic test_byte_store();
    obs_t o;
    run_access(1'b0, 1'b1, 4'h1, 32'h103, 32'hAB, 32'h0, 0, o);
    n_checks++;
    if (o.addr !== 32'h100 || o.be !== 4'b1000) begin
      n_fail++;
      $display("FAIL byte_store_bus got a%h be%b exp a100 be1000",
               o.addr, o.be);
    end
    n_checks++;
    if (o.wdata !== 32'hAB000000) begin
      n_fail++;
      $display("FAIL byte_store_wdata got %h exp ab000000", o.wdata);
    end
  endtask

  task automatic test_half_load_delay();
    obs_t o;
    run_access(1'b1, 1'b0, 4'h3, 32'h202, 32'h0, 32'h12345678, 3, o);
    n_checks++;
    if (o.rv_c !== 1 || o.rdata !== 32'h00001234) begin
      n_fail++;
      $display("FAIL half_load_rdata got rv%0d %h exp rv1 00001234",
               o.rv_c, o.rdata);
    end
    n_checks++;
    if (o.stall_c !== 5 || o.hung) begin
      n_fail++;
      $display("FAIL half_load_stall got %0d exp 5", o.stall_c);
    end
    n_checks++;
    if (o.addr !== 32'h200 || o.be !== 4'b1100 || o.unstable) begin
      n_fail++;
      $display("FAIL half_load_bus got a%h be%b unst%0d exp a200 be1100",
               o.addr, o.be, o.unstable);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_access(1'b1, 1'b0, 4'h3, 32'h203, 32'h0, 32'hFFFFFFFF, 0, o);
    n_checks++;
    if (o.mis_c !== 1 || o.valid_c !== 0 || o.stall_c !== 1) begin
      n_fail++;
      $display("FAIL mis_half got em%0d v%0d st%0d exp 1 0 1",
               o.mis_c, o.valid_c, o.stall_c);
    end
    run_access(1'b0, 1'b1, 4'hF, 32'h101, 32'h55, 32'h0, 0, o);
    n_checks++;
    if (o.mis_c !== 1 || o.valid_c !== 0 || o.stall_c !== 1) begin
      n_fail++;
      $display("FAIL mis_word got em%0d v%0d st%0d exp 1 0 1",
               o.mis_c, o.valid_c, o.stall_c);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 32'hCAFEF00D, -1, o);
    n_checks++;
    if (o.to_c !== 1 || o.valid_c !== TO + 1) begin
      n_fail++;
      $display("FAIL timeout got et%0d valid%0d exp 1 %0d",
               o.to_c, o.valid_c, TO + 1);
    end
    n_checks++;
    if (o.rdata !== 32'd0 || o.stall_c !== TO + 2) begin
      n_fail++;
      $display("FAIL timeout_data got rd%h st%0d exp 0 %0d",
               o.rdata, o.stall_c, TO + 2);
    end
  endtask

  task automatic test_reset_busy();
    int pulses;
    pulses = 0;
    req_read  = 1'b1;
    req_mask  = 4'hF;
    req_addr  = 32'h40;
    bus_if.bus_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus_if.bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre got valid %b exp 1", bus_if.bus_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus_if.bus_valid !== 1'b0 || stall !== 1'b0 ||
        dut.state !== LSU_IDLE) begin
      n_fail++;
      $display("FAIL rst_busy got valid%b stall%b st%0d exp 0 0 0",
               bus_if.bus_valid, stall, dut.state);
    end
    pulses += int'(rdata_valid) + int'(err_misaligned) + int'(err_timeout);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    req_read = 1'b0;
    @(negedge clk);
    pulses += int'(rdata_valid) + int'(err_misaligned) + int'(err_timeout);
    n_checks++;
    if (pulses !== 0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_pulses got %0d stall%b exp 0 0",
               pulses, stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_access(1'b0, 1'b1, 4'h3, 32'h500, 32'h0000BEEF, 32'h0, 0, o1);
    run_access(1'b1, 1'b1, 4'h1, 32'h501, 32'h00000077, 32'h0, 1, o2);
    n_checks++;
    if (o1.be !== 4'b0011 || o1.stall_c !== 2) begin
      n_fail++;
      $display("FAIL b2b_first got be%b st%0d exp 0011 2",
               o1.be, o1.stall_c);
    end
    n_checks++;
    if (o2.be !== 4'b0010 || o2.we !== 1'b1 || o2.wdata !== 32'h7700 ||
        o2.stall_c !== 3 || o2.rv_c !== 0) begin
      n_fail++;
      $display("FAIL b2b_second got be%b we%b d%h st%0d rv%0d exp 0010 1 7700 3 0",
               o2.be, o2.we, o2.wdata, o2.stall_c, o2.rv_c);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    bit          mis, to;
    logic [3:0]  mask, be;
    logic [31:0] addr, wd, brd, wsh, rext, exp_rd;
    logic        rd, wr;
    int          delay, k, ev;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      mask = (k == 0) ? 4'h1 : (k == 1) ? 4'h3 :
             (k == 3) ? 4'($urandom) : 4'hF;
      addr = $urandom;
      wd   = $urandom;
      brd  = $urandom;
      k    = $urandom_range(0, 2);
      rd   = (k != 1);
      wr   = (k != 0);
      delay = $urandom_range(0, 6);
      if (delay == 6) delay = -1;
      model(mask, addr, wd, brd, mis, be, wsh, rext);
      to = !mis && times_out(delay);
      ev = exp_valid(mis, delay);
      exp_rd = (mis || to) ? 32'd0 : rext;
      run_access(rd, wr, mask, addr, wd, brd, delay, o);
      n_checks++;
      if (o.hung || o.stall_c !== ev + 1 || o.valid_c !== ev) begin
        n_fail++;
        $display("FAIL rnd%0d_timing got st%0d v%0d exp %0d %0d",
                 i, o.stall_c, o.valid_c, ev + 1, ev);
      end
      n_checks++;
      if (o.mis_c !== int'(mis) || o.to_c !== int'(to) ||
          o.rv_c !== int'(!wr)) begin
        n_fail++;
        $display("FAIL rnd%0d_pulses got em%0d et%0d rv%0d exp %0d %0d %0d",
                 i, o.mis_c, o.to_c, o.rv_c, mis, to, !wr);
      end
      if (!mis) begin
        n_checks++;
        if (o.addr !== {addr[31:2], 2'b00} || o.be !== be ||
            o.we !== wr || o.unstable) begin
          n_fail++;
          $display("FAIL rnd%0d_bus got a%h be%b we%b unst%0d exp a%h be%b we%b",
                   i, o.addr, o.be, o.we, o.unstable,
                   {addr[31:2], 2'b00}, be, wr);
        end
        if (wr) begin
          n_checks++;
          if (o.wdata !== wsh) begin
            n_fail++;
            $display("FAIL rnd%0d_wdata got %h exp %h", i, o.wdata, wsh);
          end
        end
      end
      if (!wr) begin
        n_checks++;
        if (o.rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL rnd%0d_rdata got %h exp %h", i, o.rdata, exp_rd);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_read  = 1'b0;
    req_write = 1'b0;
    req_mask  = 4'h0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_word_store();
    test_byte_store();
    test_half_load_delay();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
